serial_nibble_adder: RTL
========================

Name: serial_nibble_adder

Overview:
- Sequential multi-nibble adder: accepts two NIBBLES*4-bit operands plus carry-in and adds them one 4-bit nibble per clock, LSB nibble first.
- Carry is held in a register between nibbles.
- Sits upstream of the 4-bit combinational adder datapath. It sequences operand nibbles into a 4-bit add stage and collects sum nibbles and final carry into a result register.
- Lets wide additions reuse a single 4-bit adder.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin an addition; sampled on the rising edge of clk.
- a  in  W  operand A, sampled only on accepted start.
- b  in  W  operand B, sampled only on accepted start.
- cin  in  1  carry-in into nibble 0, sampled only on accepted start.
- busy  out  1  high while nibbles are being processed.
- done  out  1  one-cycle pulse; sum and cout are valid.
- sum  out  W  result, held until the next accepted start.
- cout  out  1  carry out of the top nibble, held with sum.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal index=0, carry register=0, operand registers=0.
- Reset asserted mid-operation aborts immediately. No done pulse is issued, and outputs return to reset values.
- State machine: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge latches a, b, cin, sets idx=0, clears sum to 0 and goes to RUN. start=0 stays in IDLE.
  - RUN: each edge computes {c, s} = a[idx] + b[idx] + carry (4-bit nibbles, 5-bit result). It writes s into sum[idx*4 +: 4] and sets carry=c.
    - If idx==NIBBLES-1: cout=c, go to DONE.
    - Otherwise idx++.
  - DONE: done=1 for exactly this one cycle, then back to IDLE. A start seen at the DONE edge is accepted exactly as in IDLE (back-to-back operation, next state RUN).
- busy=1 exactly while state==RUN.
- start is ignored while in RUN; operands are not re-sampled.
- Latency: start accepted at edge k; done high in the cycle following edge k+NIBBLES. With NIBBLES=4 that is 4 edges after acceptance. Throughput is one addition per NIBBLES+1 cycles.
- Arithmetic: unsigned, modulo 2^W, with overflow reported only via cout. The carry chain is exact across nibbles, e.g. 0xFFFF+0x0001 ripples over 4 cycles.
- sum is updated nibble by nibble during RUN; it is only guaranteed valid when done=1 and afterwards, until the next acceptance.
- Inputs a, b and cin may change freely after acceptance without affecting the result.

Optional Feature:
- Macro: SERIAL_NIBBLE_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - sub=1 computes a - b as a + ~b + 1. The latched b is inverted and the initial carry is forced to 1; cin is ignored.
  - cout=1 means no borrow.
  - sub=0 behaves as an add.
- Undefined: no sub port; add only.
- Timing is identical in both builds.

Decomposition:
- Shared package serial_nibble_adder_pkg holds:
  - enum state_t {IDLE, RUN, DONE}, 2-bit encoding;
  - localparam NIBBLE_W=4.
- Natural sub-module: nibble_add4, a purely combinational 4-bit + carry adder with outputs {c, s}, instantiated once in the datapath.
- The FSM, index counter and registers stay in the top.

Test Plan:
- NIBBLES=4, a=0x0007, b=0x0006, cin=0, start for 1 cycle -> busy for 4 cycles, done pulses once on the 5th cycle; sum=0x000D, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0x0C00, b=0x0800, cin=1 -> sum=0x1401, cout=0.
- Back-to-back:
  - start held high continuously with a=0x1234, b=0x1111 -> sum=0x2345.
  - Change operands to a=0x8000, b=0x8000 at the DONE edge -> second done 5 cycles later with sum=0x0000, cout=1.
  - start pulses while busy=1 are ignored.
- Reset mid-op: a=0xAAAA, b=0x5555, assert rst asynchronously during the 2nd RUN cycle -> busy=0, done=0, sum=0, cout=0 immediately; no done pulse afterwards; a fresh add of 0x0001+0x0001 then gives 0x0002.
- With SERIAL_NIBBLE_ADDER_SUB_EN, sub=1:
  - a=0x0005, b=0x000A -> sum=0xFFFB, cout=0.
  - a=0x000A, b=0x0005 -> sum=0x0005, cout=1.
- NIBBLES=1, a=0x9, b=0x8, cin=1 -> done 2 cycles after start, sum=0x2, cout=1.

Source files
------------

// File: rtl/serial_nibble_adder_pkg.sv
// rtl/serial_nibble_adder_pkg.sv - shared types and constants for the serial nibble adder
// Optional subtract build: define SERIAL_NIBBLE_ADDER_SUB_EN.

package serial_nibble_adder_pkg;

   // Width of the single add stage reused for every nibble
   localparam int NIBBLE_W = 4;

   // Sequencer states: waiting, walking nibbles, one-cycle result strobe
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_nibble_adder_pkg

// File: rtl/nibble_add4.sv
// rtl/nibble_add4.sv - combinational 4-bit adder with carry in and carry out

module nibble_add4
   import serial_nibble_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a_i,
   input  logic [NIBBLE_W-1:0] b_i,
   input  logic                c_i,
   output logic [NIBBLE_W-1:0] s_o,
   output logic                c_o
);

   // Zero-extend everything to NIBBLE_W+1 so the carry falls out of the top bit
   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, c_i};

endmodule : nibble_add4

// File: rtl/serial_nibble_adder.sv
// rtl/serial_nibble_adder.sv - multi-nibble adder that reuses one 4-bit add stage, LSB nibble first
// Optional subtract build: define SERIAL_NIBBLE_ADDER_SUB_EN (adds sub_i; a - b as a + ~b + 1).

module serial_nibble_adder
   import serial_nibble_adder_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIBBLE_W * NIBBLES
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
   input  logic         sub_i,
`endif
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   // A one-nibble build still needs a 1-bit index so the counter is never zero width
   localparam int              IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q;
   logic [W-1:0]        a_q;
   logic [W-1:0]        b_q;
   logic [W-1:0]        sum_q;
   logic                carry_q;
   logic                cout_q;

   logic                accept;
   logic                last_nib;
   logic [W-1:0]        b_load;
   logic                carry_load;
   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] nib_s;
   logic                nib_c;

   // A new request is taken in IDLE and also on the DONE cycle for back-to-back use
   assign accept   = start_i && ((state_q == IDLE) || (state_q == DONE));
   assign last_nib = (idx_q == LAST_IDX);

`ifdef SERIAL_NIBBLE_ADDER_SUB_EN
   // Subtract folds into the add: invert b once at load and seed the carry with 1
   assign b_load     = sub_i ? ~b_i : b_i;
   assign carry_load = sub_i ? 1'b1 : cin_i;
`else
   assign b_load     = b_i;
   assign carry_load = cin_i;
`endif

   // Current nibble of each latched operand feeds the shared add stage
   assign nib_a = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
   assign nib_b = b_q[idx_q * NIBBLE_W +: NIBBLE_W];

   nibble_add4 u_add (
      .a_i (nib_a),
      .b_i (nib_b),
      .c_i (carry_q),
      .s_o (nib_s),
      .c_o (nib_c)
   );

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: RUN lasts exactly NIBBLES cycles, DONE exactly one
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_nib) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = start_i ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status outputs decoded straight from the state
   always_comb begin
      busy_o = 1'b0;
      done_o = 1'b0;
      case (state_q)
         RUN:     busy_o = 1'b1;
         DONE:    done_o = 1'b1;
         default: begin
            busy_o = 1'b0;
            done_o = 1'b0;
         end
      endcase
   end

   // Datapath: latch operands on acceptance, then retire one nibble per RUN cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         a_q     <= a_i;
         b_q     <= b_load;
         carry_q <= carry_load;
         sum_q   <= '0;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         sum_q[idx_q * NIBBLE_W +: NIBBLE_W] <= nib_s;
         carry_q <= nib_c;
         if (last_nib) begin
            cout_q <= nib_c;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign sum_o  = sum_q;
   assign cout_o = cout_q;

endmodule : serial_nibble_adder
